// File: rtl/tb_porta_rd_seq.sv
// Read sequencer for TB BRAM port A: issues one read per row and delays the
// {dest, dir, lk0} tag by the BRAM read latency so it lines up with TB_douta.
module tb_porta_rd_seq #(
  parameter int TB_AW  = 10,
  parameter int CNT_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [TB_AW-1:0] cmd_base_addr,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic             cmd_addr_dec,
  input  logic             cmd_dest,
  input  logic [1:0]       cmd_dir,
  input  logic             cmd_lk0,
  output logic             TB_ena,
  output logic [TB_AW-1:0] TB_addra,
  output logic [2:0]       TB_douta_sel,
  output logic             l_k_0,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [1:0] DRAIN_INIT = 2'(RD_LAT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_rows_left;
  logic [CNT_W-1:0] w_rows_left_nxt;
  logic [1:0]       r_drain_cnt;
  logic [1:0]       w_drain_cnt_nxt;
  logic [TB_AW-1:0] w_addr_nxt;
  logic             w_accept;

  logic             r_dec;
  logic             r_dest;
  logic [1:0]       r_dir;
  logic             r_lk0;

  logic [3:0]       r_tag_p [RD_LAT];

  assign w_accept = cmd_valid && cmd_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_rows_left_nxt = r_rows_left;
    w_drain_cnt_nxt = r_drain_cnt;
    w_addr_nxt      = TB_addra;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_addr_nxt      = cmd_base_addr;
          w_rows_left_nxt = cmd_len;
          w_state_nxt     = (cmd_len == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_rows_left_nxt = r_rows_left - 1'b1;
        if (r_rows_left == CNT_W'(1)) begin
          w_state_nxt     = S_DRAIN;
          w_drain_cnt_nxt = DRAIN_INIT;
        end else begin
          // address wraps modulo 2^TB_AW in either direction
          w_addr_nxt = r_dec ? (TB_addra - 1'b1) : (TB_addra + 1'b1);
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == 2'd0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_drain_cnt_nxt = r_drain_cnt - 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Control registers; every output is a flop decoded from the next state.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_state     <= S_IDLE;
      r_rows_left <= '0;
      r_drain_cnt <= 2'd0;
      cmd_ready   <= 1'b1;
      TB_ena      <= 1'b0;
      TB_addra    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rows_left <= w_rows_left_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      cmd_ready   <= (w_state_nxt == S_IDLE);
      TB_ena      <= (w_state_nxt == S_ISSUE);
      TB_addra    <= w_addr_nxt;
      busy        <= (w_state_nxt != S_IDLE);
      done        <= (w_state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_dec  <= cmd_addr_dec;
      r_dest <= cmd_dest;
      r_dir  <= cmd_dir;
      r_lk0  <= cmd_lk0;
    end
  end

  // Tag pipeline: entries are stored already zeroed when no read was issued,
  // so the last stage drives TB_douta_sel/l_k_0 directly.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_tag_p[i] <= 4'd0;
      end
    end else begin
      r_tag_p[0] <= TB_ena ? {r_dest, r_dir, r_lk0} : 4'd0;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_p[i] <= r_tag_p[i-1];
      end
    end
  end

  assign TB_douta_sel = r_tag_p[RD_LAT-1][3:1];
  assign l_k_0        = r_tag_p[RD_LAT-1][0];

endmodule

// File: tb/tb_tb_porta_rd_seq.sv
// Bench for tb_porta_rd_seq: two instances (RD_LAT=1 and RD_LAT=2) share stimulus and are
// checked each cycle against a closed-form timeline plus an address scoreboard.
module tb_tb_porta_rd_seq;
  localparam int AW = 10;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          sys_rst;
  logic          cmd_valid;
  logic [AW-1:0] cmd_base_addr;
  logic [CW-1:0] cmd_len;
  logic          cmd_addr_dec;
  logic          cmd_dest;
  logic [1:0]    cmd_dir;
  logic          cmd_lk0;

  logic [1:0]    rdy, ena, lk, bsy, dn;
  logic [AW-1:0] addr0, addr1;
  logic [2:0]    sel0, sel1;

  tb_porta_rd_seq #(.TB_AW(AW), .CNT_W(CW), .RD_LAT(1)) u_dut1 (
    .clk(clk), .sys_rst(sys_rst), .cmd_valid(cmd_valid), .cmd_ready(rdy[0]),
    .cmd_base_addr(cmd_base_addr), .cmd_len(cmd_len), .cmd_addr_dec(cmd_addr_dec),
    .cmd_dest(cmd_dest), .cmd_dir(cmd_dir), .cmd_lk0(cmd_lk0),
    .TB_ena(ena[0]), .TB_addra(addr0), .TB_douta_sel(sel0), .l_k_0(lk[0]),
    .busy(bsy[0]), .done(dn[0]));

  tb_porta_rd_seq #(.TB_AW(AW), .CNT_W(CW), .RD_LAT(2)) u_dut2 (
    .clk(clk), .sys_rst(sys_rst), .cmd_valid(cmd_valid), .cmd_ready(rdy[1]),
    .cmd_base_addr(cmd_base_addr), .cmd_len(cmd_len), .cmd_addr_dec(cmd_addr_dec),
    .cmd_dest(cmd_dest), .cmd_dir(cmd_dir), .cmd_lk0(cmd_lk0),
    .TB_ena(ena[1]), .TB_addra(addr1), .TB_douta_sel(sel1), .l_k_0(lk[1]),
    .busy(bsy[1]), .done(dn[1]));

  typedef struct packed {
    logic [AW-1:0] base;
    logic [CW-1:0] len;
    logic          dec;
    logic          dest;
    logic [1:0]    dir;
    logic          lk0;
    logic          hold;      // keep cmd_valid high while busy
    logic [2:0]    exp_sel;
    logic          exp_lk0;
    logic [AW-1:0] exp_last;  // address of the final row
  } vec_t;

  typedef struct packed {
    logic          ena;
    logic [AW-1:0] addr;
    logic [2:0]    sel;
    logic          lk0;
    logic          busy;
    logic          done;
    logic          ready;
  } out_t;

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] q0[$];
  logic [AW-1:0] q1[$];
  logic [AW-1:0] last0;
  vec_t vecs[6];

  localparam out_t IDLE_OUT = '{ena: 1'b0, addr: '0, sel: 3'b000, lk0: 1'b0,
                                busy: 1'b0, done: 1'b0, ready: 1'b1};

  function automatic out_t model(input vec_t v, input int L, input int k);
    out_t m;
    int n, lastk;
    n     = int'(v.len);
    lastk = (n == 0) ? 1 : n + L + 1;
    m.ena   = (k >= 1 && k <= n);
    m.addr  = m.ena ? (v.dec ? AW'(int'(v.base) - (k - 1)) : AW'(int'(v.base) + (k - 1))) : '0;
    m.sel   = (k - L >= 1 && k - L <= n) ? v.exp_sel : 3'b000;
    m.lk0   = (k - L >= 1 && k - L <= n) ? v.exp_lk0 : 1'b0;
    m.done  = (k == lastk);
    m.busy  = (k >= 1 && k <= lastk);
    m.ready = (k == 0) || (k > lastk);
    return m;
  endfunction

  function automatic out_t actual(input int d, input logic use_addr);
    out_t a;
    a.ena   = ena[d];
    a.addr  = use_addr ? ((d == 0) ? addr0 : addr1) : '0;
    a.sel   = (d == 0) ? sel0 : sel1;
    a.lk0   = lk[d];
    a.busy  = bsy[d];
    a.done  = dn[d];
    a.ready = rdy[d];
    return a;
  endfunction

  task automatic cmp(input string nm, input int d, input int k, input out_t a, input out_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s dut_lat%0d k=%0d got{ena,addr,sel,lk0,busy,done,rdy}=%b_%h_%b_%b_%b_%b_%b exp=%b_%h_%b_%b_%b_%b_%b",
               nm, d + 1, k, a.ena, a.addr, a.sel, a.lk0, a.busy, a.done, a.ready,
               e.ena, e.addr, e.sel, e.lk0, e.busy, e.done, e.ready);
    end
  endtask

  task automatic check_cycle(input vec_t v, input int k, input string nm);
    out_t e;
    for (int d = 0; d < 2; d++) begin
      e = model(v, d + 1, k);
      cmp(nm, d, k, actual(d, e.ena), e);
    end
  endtask

  task automatic check_idle(input string nm, input int k);
    for (int d = 0; d < 2; d++) cmp(nm, d, k, actual(d, 1'b1), IDLE_OUT);
  endtask

  task automatic sb_pop(input string nm);
    logic [AW-1:0] e;
    if (ena[0]) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL %s sb_lat1 extra read addr=%h exp=none", nm, addr0);
      end else begin
        e = q0.pop_front();
        if (addr0 !== e) begin
          errors++;
          $display("FAIL %s sb_lat1 addr got=%h exp=%h", nm, addr0, e);
        end
        last0 = addr0;
      end
    end
    if (ena[1]) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL %s sb_lat2 extra read addr=%h exp=none", nm, addr1);
      end else begin
        e = q1.pop_front();
        if (addr1 !== e) begin
          errors++;
          $display("FAIL %s sb_lat2 addr got=%h exp=%h", nm, addr1, e);
        end
      end
    end
  endtask

  task automatic drive_cmd(input vec_t v);
    cmd_valid     = 1'b1;
    cmd_base_addr = v.base;
    cmd_len       = v.len;
    cmd_addr_dec  = v.dec;
    cmd_dest      = v.dest;
    cmd_dir       = v.dir;
    cmd_lk0       = v.lk0;
    for (int r = 0; r < int'(v.len); r++) begin
      q0.push_back(v.dec ? AW'(int'(v.base) - r) : AW'(int'(v.base) + r));
      q1.push_back(v.dec ? AW'(int'(v.base) - r) : AW'(int'(v.base) + r));
    end
  endtask

  task automatic scramble_cmd();
    cmd_base_addr = AW'($urandom);
    cmd_len       = CW'($urandom);
    cmd_addr_dec  = 1'($urandom);
    cmd_dest      = 1'($urandom);
    cmd_dir       = 2'($urandom);
    cmd_lk0       = 1'($urandom);
  endtask

  // Entered at a negedge with both DUTs idle; returns at a negedge.
  task automatic run_cmd(input vec_t v, input string nm);
    int n, drop_k;
    n      = int'(v.len);
    drop_k = ((n == 0) ? 1 : n + 2) + 1;
    last0  = '0;
    drive_cmd(v);
    check_cycle(v, 0, nm);
    for (int k = 1; k <= n + 6; k++) begin
      @(negedge clk);
      check_cycle(v, k, nm);
      sb_pop(nm);
      scramble_cmd();
      if (!v.hold || k >= drop_k) cmd_valid = 1'b0;
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL %s sb_left got=%0d/%0d exp=0/0", nm, q0.size(), q1.size());
    end
    q0.delete();
    q1.delete();
    if (n > 0) begin
      checks++;
      if (last0 !== v.exp_last) begin
        errors++;
        $display("FAIL %s last_addr got=%h exp=%h", nm, last0, v.exp_last);
      end
    end
  endtask

  initial begin
    vec_t v6;
    //          base     len   dec   dest  dir    lk0   hold  sel     lk    last
    vecs[0] = {10'h010, 8'd4, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 3'b001, 1'b0, 10'h013};
    vecs[1] = {10'h001, 8'd3, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 3'b110, 1'b0, 10'h3FF};
    vecs[2] = {10'h200, 8'd2, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 3'b011, 1'b1, 10'h201};
    vecs[3] = {10'h3FE, 8'd4, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 3'b100, 1'b0, 10'h001};
    vecs[4] = {10'h055, 8'd0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b1, 3'b000, 1'b0, 10'h000};
    vecs[5] = {10'h123, 8'd1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 3'b101, 1'b1, 10'h123};

    sys_rst   = 1'b1;
    cmd_valid = 1'b0;
    scramble_cmd();
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_idle("reset_hold", k);
    end
    sys_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_idle("reset_idle", k);
    end

    for (int i = 0; i < 6; i++) begin
      run_cmd(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while ISSUE is in progress aborts the command without a done pulse.
    v6 = {10'h0F0, 8'd8, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 3'b001, 1'b1, 10'h0F7};
    drive_cmd(v6);
    check_cycle(v6, 0, "abort");
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_cycle(v6, k, "abort");
      sb_pop("abort");
      cmd_valid = 1'b0;
    end
    sys_rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) cmp("abort_rst", d, 0, actual(d, 1'b1), IDLE_OUT);
    sys_rst = 1'b0;
    q0.delete();
    q1.delete();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check_idle("abort_after", k);
    end
    run_cmd(vecs[0], "post_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
